// File: rtl/bp_mig_pkg.sv
// Shared types for the bsg_cache DMA to MIG app-interface bridge.
package bp_mig_pkg;

  typedef enum logic [2:0] {
    e_mig_cmd_write = 3'b000,
    e_mig_cmd_read  = 3'b001
  } bp_mig_cmd_e;

  typedef enum logic [1:0] {
    e_idle,
    e_rd_cmd,
    e_rd_drain,
    e_wr
  } bp_mig_state_e;

endpackage

// File: rtl/bp_cache_dma_to_mig_app_if.sv
// Bundles the cache DMA port and the MIG app port seen by the bridge.
// slave = the bridge, master = the cache/MIG environment around it.
interface bp_cache_dma_to_mig_app_if #(
  parameter int caddr_width_p    = 28,
  parameter int data_width_p     = 128,
  parameter int app_addr_width_p = 28
);
  logic [caddr_width_p:0]      dma_pkt;
  logic                        dma_pkt_v;
  logic                        dma_pkt_yumi;
  logic [data_width_p-1:0]     dma_rdata;
  logic                        dma_rdata_v;
  logic                        dma_rdata_ready_and;
  logic [data_width_p-1:0]     dma_wdata;
  logic                        dma_wdata_v;
  logic                        dma_wdata_yumi;
  logic [app_addr_width_p-1:0] app_addr;
  logic [2:0]                  app_cmd;
  logic                        app_en;
  logic                        app_rdy;
  logic [data_width_p-1:0]     app_wdf_data;
  logic [data_width_p/8-1:0]   app_wdf_mask;
  logic                        app_wdf_wren;
  logic                        app_wdf_end;
  logic                        app_wdf_rdy;
  logic [data_width_p-1:0]     app_rd_data;
  logic                        app_rd_data_valid;
  logic                        init_calib_complete;

  modport slave (
    input  dma_pkt, dma_pkt_v, dma_rdata_ready_and, dma_wdata, dma_wdata_v,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, init_calib_complete,
    output dma_pkt_yumi, dma_rdata, dma_rdata_v, dma_wdata_yumi,
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );

  modport master (
    output dma_pkt, dma_pkt_v, dma_rdata_ready_and, dma_wdata, dma_wdata_v,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, init_calib_complete,
    input  dma_pkt_yumi, dma_rdata, dma_rdata_v, dma_wdata_yumi,
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );

endinterface

// File: rtl/bp_mig_rd_buffer.sv
// Small 1r1w FIFO catching MIG read returns, which cannot be stalled.
// A push while full is dropped and flagged on overflow_o.
module bp_mig_rd_buffer #(
  parameter int els_p   = 4,
  parameter int width_p = 128
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               ready_and_i,
  output logic               overflow_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] cnt_full_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic                full, push, pop;

  assign full       = (cnt_r == cnt_full_lp);
  assign push       = v_i & ~full;
  assign pop        = v_o & ready_and_i;
  assign overflow_o = v_i & full;
  assign v_o        = (cnt_r != '0);
  assign data_o     = v_o ? mem[rptr_r] : '0;

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_r] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (push) wptr_r <= (wptr_r == ptr_last_lp) ? '0 : wptr_r + ptr_w_lp'(1);
      if (pop)  rptr_r <= (rptr_r == ptr_last_lp) ? '0 : rptr_r + ptr_w_lp'(1);
      case ({push, pop})
        2'b10:   cnt_r <= cnt_r + cnt_w_lp'(1);
        2'b01:   cnt_r <= cnt_r - cnt_w_lp'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/bp_cache_dma_to_mig_app.sv
// Responder for bsg_cache block DMA packets; emits one MIG app command per beat.
// Reads return through a buffer, writes pass straight through with no storage.
//
// state      | meaning
// e_idle     | waiting for a packet, accepted only once calibrated
// e_rd_cmd   | issuing one read command per beat
// e_rd_drain | all reads issued, forwarding buffered returns to the cache
// e_wr       | passing write beats from the cache to the MIG
module bp_cache_dma_to_mig_app
  import bp_mig_pkg::*;
#(
  parameter int caddr_width_p    = 28,
  parameter int block_width_p    = 512,
  parameter int fill_width_p     = 128,
  parameter int app_data_width_p = 128,
  parameter int app_addr_width_p = 28,
  parameter int app_addr_shift_p = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  bp_cache_dma_to_mig_app_if.slave io,
  output logic                     error_o
);

  localparam int beats_lp    = block_width_p / fill_width_p;
  localparam int app_step_lp = (fill_width_p / 8) >> app_addr_shift_p;
  localparam int blk_off_lp  = $clog2(block_width_p / 8);
  localparam int cnt_w_lp    = $clog2(beats_lp + 1);
  localparam logic [cnt_w_lp-1:0]      last_lp     = cnt_w_lp'(beats_lp - 1);
  localparam logic [caddr_width_p-1:0] blk_mask_lp = {caddr_width_p{1'b1}} << blk_off_lp;

  bp_mig_state_e state_r, state_n;
  logic [caddr_width_p-1:0] base_r, base_n, addr_full;
  logic [cnt_w_lp-1:0]      beat_r, beat_n, pop_r, pop_n, rcv_r, rcv_n;
  logic                     error_r;

  logic                     pkt_wnr;
  logic [caddr_width_p-1:0] pkt_addr;
  logic                     pkt_yumi, rd_en, wr_fire;
  logic                     rd_outstanding, buf_push, buf_pop, buf_v, buf_overflow;
  logic [app_data_width_p-1:0] buf_data;

  assign pkt_wnr  = io.dma_pkt[caddr_width_p];
  assign pkt_addr = io.dma_pkt[caddr_width_p-1:0];

  // A return is legitimate only while fewer beats came back than were requested.
  assign rd_outstanding = ((state_r == e_rd_cmd) || (state_r == e_rd_drain)) && (rcv_r != beat_r);
  assign buf_push       = io.app_rd_data_valid & rd_outstanding;
  assign buf_pop        = buf_v & io.dma_rdata_ready_and;

  bp_mig_rd_buffer #(
    .els_p   (beats_lp),
    .width_p (app_data_width_p)
  ) rd_buf (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .data_i      (io.app_rd_data),
    .v_i         (buf_push),
    .data_o      (buf_data),
    .v_o         (buf_v),
    .ready_and_i (io.dma_rdata_ready_and),
    .overflow_o  (buf_overflow)
  );

  always_comb begin
    state_n  = state_r;
    base_n   = base_r;
    beat_n   = beat_r;
    pop_n    = pop_r + cnt_w_lp'(buf_pop);
    rcv_n    = rcv_r + cnt_w_lp'(buf_push);
    pkt_yumi = 1'b0;
    rd_en    = 1'b0;
    wr_fire  = 1'b0;
    case (state_r)
      e_idle: begin
        pkt_yumi = io.dma_pkt_v & io.init_calib_complete;
        if (pkt_yumi) begin
          base_n  = pkt_addr & blk_mask_lp;
          beat_n  = '0;
          pop_n   = '0;
          rcv_n   = '0;
          state_n = pkt_wnr ? e_wr : e_rd_cmd;
        end
      end
      e_rd_cmd: begin
        rd_en = 1'b1;
        if (io.app_rdy) begin
          beat_n = beat_r + cnt_w_lp'(1);
          if (beat_r == last_lp) state_n = e_rd_drain;
        end
      end
      e_rd_drain: begin
        if (buf_pop && (pop_r == last_lp)) state_n = e_idle;
      end
      e_wr: begin
        wr_fire = io.dma_wdata_v & io.app_rdy & io.app_wdf_rdy;
        if (wr_fire) begin
          beat_n = beat_r + cnt_w_lp'(1);
          if (beat_r == last_lp) state_n = e_idle;
        end
      end
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      base_r  <= '0;
      beat_r  <= '0;
      pop_r   <= '0;
      rcv_r   <= '0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_n;
      base_r  <= base_n;
      beat_r  <= beat_n;
      pop_r   <= pop_n;
      rcv_r   <= rcv_n;
      error_r <= error_r | (io.app_rd_data_valid & ~rd_outstanding) | buf_overflow;
    end
  end

  assign addr_full = (base_r >> app_addr_shift_p)
                   + (caddr_width_p'(beat_r) * caddr_width_p'(app_step_lp));

  assign io.dma_pkt_yumi   = pkt_yumi;
  assign io.dma_rdata      = buf_data;
  assign io.dma_rdata_v    = buf_v;
  assign io.dma_wdata_yumi = wr_fire;
  assign io.app_addr       = app_addr_width_p'(addr_full);
  assign io.app_cmd        = (state_r == e_rd_cmd) ? e_mig_cmd_read : e_mig_cmd_write;
  assign io.app_en         = rd_en | wr_fire;
  assign io.app_wdf_data   = (state_r == e_wr) ? io.dma_wdata : '0;
  assign io.app_wdf_mask   = '0;
  assign io.app_wdf_wren   = wr_fire;
  assign io.app_wdf_end    = 1'b1;
  assign error_o           = error_r;

endmodule

// File: tb/tb_bp_cache_dma_to_mig_app.sv
// Scoreboard bench for the DMA-to-MIG bridge with random cache and MIG behaviour.
module tb_bp_cache_dma_to_mig_app;

  localparam int AW = 28;
  localparam int DW = 128;

  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    cmd;
    logic [DW-1:0] data;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic error;

  int checks = 0;
  int errors = 0;

  cmd_t          exp_cmd_q[$];
  logic [DW-1:0] exp_rd_q[$];
  logic [DW-1:0] mig_pend[$];
  logic [DW-1:0] wr_q[$];

  int mig_mode     = 0;
  bit hold_ready   = 1'b0;
  bit spurious_req = 1'b0;
  int rd_delivered = 0;

  bp_cache_dma_to_mig_app_if #(.caddr_width_p(AW), .data_width_p(DW), .app_addr_width_p(AW)) io();

  bp_cache_dma_to_mig_app #(
    .caddr_width_p(AW), .block_width_p(512), .fill_width_p(DW),
    .app_data_width_p(DW), .app_addr_width_p(AW), .app_addr_shift_p(1)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .io(io), .error_o(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Block-aligned byte address, converted to DQ words, plus 8 words per beat.
  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input int i);
    longint unsigned base;
    base = (longint'(a) / 64) * 64;
    return AW'(base / 2 + longint'(i) * 8);
  endfunction

  task automatic push_exp(input bit wnr, input logic [AW-1:0] a);
    cmd_t e;
    for (int i = 0; i < 4; i++) begin
      e.addr = beat_addr(a, i);
      e.cmd  = wnr ? 3'b000 : 3'b001;
      e.data = wnr ? rand_word() : '0;
      exp_cmd_q.push_back(e);
      if (wnr) wr_q.push_back(e.data);
    end
  endtask

  task automatic send_pkt(input bit wnr, input logic [AW-1:0] a);
    int n;
    push_exp(wnr, a);
    io.dma_pkt   = {wnr, a};
    io.dma_pkt_v = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!io.dma_pkt_yumi && n < 500);
    chk("pkt_yumi_in_time", DW'(n < 500), DW'(1));
    @(posedge clk); #1;
    io.dma_pkt_v = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk); #3;
      n++;
    end while ((exp_cmd_q.size() != 0 || exp_rd_q.size() != 0 || mig_pend.size() != 0
                || wr_q.size() != 0) && n < 3000);
    chk("packet_done_in_time", DW'(n < 3000), DW'(1));
    repeat (2) @(posedge clk);
    #3;
  endtask

  // Monitor: compares every handshake the DUT completes against the queues.
  initial begin
    cmd_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (io.app_en && io.app_rdy) begin
          if (exp_cmd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL app_cmd_unexpected: got addr %h cmd %0d expected none", io.app_addr, io.app_cmd);
          end else begin
            e = exp_cmd_q.pop_front();
            chk("app_addr", DW'(io.app_addr), DW'(e.addr));
            chk("app_cmd", DW'(io.app_cmd), DW'(e.cmd));
            if (e.cmd == 3'b000) begin
              chk("wdf_data", io.app_wdf_data, e.data);
              chk("wdf_mask", DW'(io.app_wdf_mask), DW'(0));
              chk("wdf_end", DW'(io.app_wdf_end), DW'(1));
            end
          end
        end
        if ((io.app_en || io.app_wdf_wren) && io.app_cmd == 3'b000) begin
          chk("wren_eq_en", DW'(io.app_wdf_wren), DW'(io.app_en));
          chk("wdata_yumi_eq_wren", DW'(io.dma_wdata_yumi), DW'(io.app_wdf_wren));
          chk("wr_fire_cond", DW'(io.app_rdy & io.app_wdf_rdy & io.dma_wdata_v), DW'(io.app_wdf_wren));
        end
        if (io.dma_rdata_v && io.dma_rdata_ready_and) begin
          if (exp_rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_beat_unexpected: got %h expected none", io.dma_rdata);
          end else begin
            chk("rd_beat", io.dma_rdata, exp_rd_q.pop_front());
          end
          rd_delivered++;
        end
      end
    end
  end

  // MIG model: accepts commands, returns read data in order after acceptance.
  initial begin
    bit acc_rd;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      acc_rd = rst_n && io.app_en && io.app_rdy && (io.app_cmd == 3'b001);
      @(posedge clk); #1;
      if (acc_rd) begin
        d = rand_word();
        mig_pend.push_back(d);
        exp_rd_q.push_back(d);
      end
      if (spurious_req) begin
        io.app_rd_data_valid = 1'b1;
        io.app_rd_data       = rand_word();
        spurious_req         = 1'b0;
      end else if (mig_pend.size() != 0 && (mig_mode == 0 || $urandom_range(0, 2) != 0)) begin
        io.app_rd_data_valid = 1'b1;
        io.app_rd_data       = mig_pend.pop_front();
      end else begin
        io.app_rd_data_valid = 1'b0;
        io.app_rd_data       = '0;
      end
      case (mig_mode)
        0: begin io.app_rdy = 1'b1; io.app_wdf_rdy = 1'b1; end
        1: begin io.app_rdy = 1'($urandom_range(0, 1)); io.app_wdf_rdy = 1'($urandom_range(0, 1)); end
        default: begin io.app_rdy = 1'b1; io.app_wdf_rdy = ~io.app_wdf_rdy; end
      endcase
    end
  end

  // Cache write-data source.
  initial begin
    bit took;
    forever begin
      @(negedge clk);
      took = rst_n && io.dma_wdata_yumi;
      @(posedge clk); #1;
      if (took && wr_q.size() != 0) wr_q.delete(0);
      if (wr_q.size() != 0 && $urandom_range(0, 3) != 0) begin
        io.dma_wdata_v = 1'b1;
        io.dma_wdata   = wr_q[0];
      end else begin
        io.dma_wdata_v = 1'b0;
        io.dma_wdata   = '0;
      end
    end
  end

  // Cache read-data sink.
  initial begin
    forever begin
      @(posedge clk); #1;
      io.dma_rdata_ready_and = !hold_ready && ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int n;
    int base_cnt;
    io.dma_pkt = '0;             io.dma_pkt_v = 1'b0;
    io.dma_wdata = '0;           io.dma_wdata_v = 1'b0;
    io.dma_rdata_ready_and = 1'b0;
    io.app_rdy = 1'b0;           io.app_wdf_rdy = 1'b0;
    io.app_rd_data = '0;         io.app_rd_data_valid = 1'b0;
    io.init_calib_complete = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_app_en", DW'(io.app_en), DW'(0));
    chk("rst_pkt_yumi", DW'(io.dma_pkt_yumi), DW'(0));
    chk("rst_rdata_v", DW'(io.dma_rdata_v), DW'(0));
    chk("rst_wren", DW'(io.app_wdf_wren), DW'(0));
    chk("rst_wdata_yumi", DW'(io.dma_wdata_yumi), DW'(0));
    chk("rst_error", DW'(error), DW'(0));
    chk("rst_app_addr", DW'(io.app_addr), DW'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    io.init_calib_complete = 1'b1;
    @(posedge clk); #3;

    // Directed read at 0x0001_0040.
    mig_mode = 0;
    send_pkt(1'b0, 28'h001_0040);
    wait_idle();
    chk("error_after_read", DW'(error), DW'(0));

    // Cache stalls while all four beats come back.
    hold_ready = 1'b1;
    send_pkt(1'b0, AW'($urandom()));
    repeat (10) @(posedge clk);
    #3;
    chk("stall_buffer_holds", DW'(io.dma_rdata_v), DW'(1));
    chk("stall_no_error", DW'(error), DW'(0));
    hold_ready = 1'b0;
    wait_idle();

    // Write at 0x100 with wdf_rdy toggling.
    mig_mode = 2;
    send_pkt(1'b1, 28'h000_0100);
    wait_idle();
    mig_mode = 0;

    // Calibration gating.
    io.init_calib_complete = 1'b0;
    push_exp(1'b0, 28'h0ab_cdc0);
    io.dma_pkt   = {1'b0, 28'h0ab_cdc0};
    io.dma_pkt_v = 1'b1;
    repeat (50) begin
      @(negedge clk);
      chk("calib_low_yumi", DW'(io.dma_pkt_yumi), DW'(0));
      chk("calib_low_app_en", DW'(io.app_en), DW'(0));
    end
    @(posedge clk); #1;
    io.init_calib_complete = 1'b1;
    @(negedge clk);
    chk("calib_rise_yumi", DW'(io.dma_pkt_yumi), DW'(1));
    @(posedge clk); #1;
    io.dma_pkt_v = 1'b0;
    wait_idle();

    // Random packets with random MIG behaviour.
    for (int p = 0; p < 24; p++) begin
      mig_mode = $urandom_range(0, 2);
      send_pkt(1'($urandom_range(0, 1)), AW'($urandom()));
      wait_idle();
    end
    mig_mode = 0;
    chk("error_after_random", DW'(error), DW'(0));

    // Reset after two of four read beats are delivered.
    base_cnt = rd_delivered;
    send_pkt(1'b0, 28'h004_2000);
    n = 0;
    while (rd_delivered < base_cnt + 2 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("two_beats_in_time", DW'(n < 500), DW'(1));
    #2;
    rst_n = 1'b0;
    exp_cmd_q.delete();
    exp_rd_q.delete();
    mig_pend.delete();
    wr_q.delete();
    #1;
    chk("midrst_app_en", DW'(io.app_en), DW'(0));
    chk("midrst_rdata_v", DW'(io.dma_rdata_v), DW'(0));
    chk("midrst_wren", DW'(io.app_wdf_wren), DW'(0));
    chk("midrst_app_addr", DW'(io.app_addr), DW'(0));
    chk("midrst_error", DW'(error), DW'(0));
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #3;
    send_pkt(1'b0, 28'h00f_ff40);
    wait_idle();
    chk("post_reset_error", DW'(error), DW'(0));

    // Spurious read return in idle.
    spurious_req = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("spurious_error", DW'(error), DW'(1));
    repeat (5) begin
      @(negedge clk);
      chk("spurious_no_rdata", DW'(io.dma_rdata_v), DW'(0));
    end
    send_pkt(1'b1, 28'h000_0040);
    wait_idle();
    chk("error_sticky", DW'(error), DW'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
